ddr_axi_master: RTL and testbench
=================================

// Module: ddr_axi_master
// PURPOSE
//  Bridges the data-cache line-transfer interface to a DDR controller AXI4 slave (MIG).
//  Each request moves one 128-bit cache line as a single-beat AXI burst.
//  Write-back and refill paths are independent FSMs and may run concurrently.
//  Sits between the dmem cache controller and the DDR2 memory controller.
// PARAMETERS
//  none; widths fixed: address 27 bits (byte address), data 128 bits, 16-byte line.
// PORTS
//  clk            in   1    single system clock
//  rst            in   1    asynchronous, active-high reset
//  wr_data        in   128  line to write back
//  wr_addr        in   27   byte address of line to write
//  wr_valid       in   1    write request
//  wr_ready       out  1    write path idle/accepting; low from accept until BRESP
//  rd_addr        in   27   byte address of line to fetch
//  rd_avalid      in   1    read request
//  rd_aready      out  1    read path idle/accepting
//  rd_data        out  128  fetched line, valid while rd_valid
//  rd_valid       out  1    fetched line available
//  rd_dready      in   1    consumer takes rd_data
//  M_AXI_AW*/W*/B*/AR*/R*   AXI4 master: AWADDR/ARADDR 27, AWLEN/ARLEN 8, *SIZE 3,
//    *BURST 2, AWLOCK 1, ARLOCK 2, *CACHE 4, *PROT 3, *QOS 4, WDATA 128, WSTRB 16,
//    WLAST, BRESP 2, RDATA 128, RRESP 2, RLAST, plus VALID/READY pairs
// BEHAVIOUR
//  Constants: *LEN=0, *SIZE=3'b100, *BURST=2'b01, *LOCK=0, *CACHE=4'b0011, *PROT=0,
//   *QOS=0, WSTRB=16'hFFFF, WLAST=1 whenever WVALID.
//  Addresses: AWADDR/ARADDR = latched address with bits [3:0] forced to 0.
//  Reset (async, immediate): both FSMs IDLE; wr_ready=1, rd_aready=1, rd_valid=0,
//   AWVALID=WVALID=BREADY=ARVALID=RREADY=0, rd_data=0. Reset mid-transfer abandons it.
//  Write FSM: W_IDLE -> W_REQ -> W_RESP -> W_IDLE.
//   W_IDLE: wr_ready=1; on wr_valid (handshake wr_valid&&wr_ready) latch addr/data,
//    next cycle wr_ready=0, AWVALID=1, WVALID=1 (issued together).
//   W_REQ: AWVALID drops the cycle after AWREADY seen; WVALID drops after WREADY;
//    either order or same cycle accepted; when both done -> W_RESP, BREADY=1.
//   W_RESP: on BVALID -> W_IDLE, BREADY=0, wr_ready=1 next cycle. BRESP ignored.
//  Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_HOLD -> R_IDLE.
//   R_IDLE: rd_aready=1; on rd_avalid latch addr, rd_aready=0, ARVALID=1.
//   R_ADDR: on ARREADY drop ARVALID, RREADY=1.
//   R_DATA: on RVALID (RLAST expected) capture RDATA into rd_data, RREADY=0,
//    rd_valid=1 next cycle. RRESP ignored; data delivered as-is.
//   R_HOLD: rd_valid held with stable rd_data until rd_dready; then rd_valid=0,
//    return R_IDLE, rd_aready=1 next cycle. rd_dready asserted early is fine.
//  Minimum latency: request accepted -> AXI valid 1 cycle; RVALID -> rd_valid 1 cycle.
//  Requests while not ready are ignored (not queued); requester must hold valid.
//  Simultaneous read+write: both FSMs progress independently; no ordering enforced.
//  Inputs wr_addr/wr_data/rd_addr may change after acceptance without effect.
// TESTING
//  Reset then idle -> wr_ready=1, rd_aready=1, all AXI VALIDs 0, rd_valid 0.
//  wr_addr=27'h0001234, wr_data=128'hDEADBEEF... with AWREADY/WREADY=1, BVALID 3
//   cycles later -> AWADDR=27'h0001230, WSTRB=FFFF, WLAST=1, wr_ready low until BRESP.
//  AWREADY delayed 5 cycles, WREADY immediate -> WVALID drops first, BREADY only
//   after AW done; wr_ready returns 1 cycle after BVALID.
//  rd_addr=27'h0ABCD0, ARREADY=1, RVALID+RLAST with RDATA=128'h0123..EF, rd_dready=1
//   -> rd_valid=1 one cycle later, rd_data=RDATA, then idle.
//  Write and read issued same cycle, slave interleaves -> both complete, data intact.
//  Assert rst during R_DATA -> rd_valid, ARVALID, RREADY 0 immediately; rd_aready=1.

Source files
------------

// File: rtl/ddr_axi_master.sv
// Cache-line bridge to a DDR controller AXI4 slave: one 128-bit line per single-beat burst.
// Write-back and refill paths are independent FSMs and may overlap.
module ddr_axi_master (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] wr_data,
    input  logic [26:0]  wr_addr,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [26:0]  rd_addr,
    input  logic         rd_avalid,
    output logic         rd_aready,
    output logic [127:0] rd_data,
    output logic         rd_valid,
    input  logic         rd_dready,
    output logic [26:0]  M_AXI_AWADDR,
    output logic [7:0]   M_AXI_AWLEN,
    output logic [2:0]   M_AXI_AWSIZE,
    output logic [1:0]   M_AXI_AWBURST,
    output logic         M_AXI_AWLOCK,
    output logic [3:0]   M_AXI_AWCACHE,
    output logic [2:0]   M_AXI_AWPROT,
    output logic [3:0]   M_AXI_AWQOS,
    output logic         M_AXI_AWVALID,
    input  logic         M_AXI_AWREADY,
    output logic [127:0] M_AXI_WDATA,
    output logic [15:0]  M_AXI_WSTRB,
    output logic         M_AXI_WLAST,
    output logic         M_AXI_WVALID,
    input  logic         M_AXI_WREADY,
    input  logic [1:0]   M_AXI_BRESP,
    input  logic         M_AXI_BVALID,
    output logic         M_AXI_BREADY,
    output logic [26:0]  M_AXI_ARADDR,
    output logic [7:0]   M_AXI_ARLEN,
    output logic [2:0]   M_AXI_ARSIZE,
    output logic [1:0]   M_AXI_ARBURST,
    output logic [1:0]   M_AXI_ARLOCK,
    output logic [3:0]   M_AXI_ARCACHE,
    output logic [2:0]   M_AXI_ARPROT,
    output logic [3:0]   M_AXI_ARQOS,
    output logic         M_AXI_ARVALID,
    input  logic         M_AXI_ARREADY,
    input  logic [127:0] M_AXI_RDATA,
    input  logic [1:0]   M_AXI_RRESP,
    input  logic         M_AXI_RLAST,
    input  logic         M_AXI_RVALID,
    output logic         M_AXI_RREADY
);
    localparam int unsigned ADDR_W = 27;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned OFFS_W = 4;

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_HOLD} r_state_t;

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;

    logic              wr_ready_nxt, aw_valid_nxt, w_valid_nxt, b_ready_nxt;
    logic [ADDR_W-1:0] aw_addr_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic              rd_aready_nxt, ar_valid_nxt, r_ready_nxt, rd_valid_nxt;
    logic [ADDR_W-1:0] ar_addr_nxt;
    logic [DATA_W-1:0] rd_data_nxt;

    // Fixed single-beat, full-line, incrementing, normal-access burst attributes
    assign M_AXI_AWLEN   = 8'd0;
    assign M_AXI_AWSIZE  = 3'b100;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWPROT  = 3'd0;
    assign M_AXI_AWQOS   = 4'd0;
    assign M_AXI_WSTRB   = 16'hFFFF;
    assign M_AXI_WLAST   = 1'b1;
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = 3'b100;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 2'b00;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'd0;
    assign M_AXI_ARQOS   = 4'd0;

    // Responses are not acted on and line offsets are always dropped
    logic unused_in;
    assign unused_in = ^{M_AXI_BRESP, M_AXI_RRESP, M_AXI_RLAST,
                         wr_addr[OFFS_W-1:0], rd_addr[OFFS_W-1:0]};

    // Write path next state; AW and W handshakes may complete in either order
    always_comb begin
        w_state_nxt  = w_state;
        wr_ready_nxt = wr_ready;
        aw_valid_nxt = M_AXI_AWVALID;
        w_valid_nxt  = M_AXI_WVALID;
        b_ready_nxt  = M_AXI_BREADY;
        aw_addr_nxt  = M_AXI_AWADDR;
        w_data_nxt   = M_AXI_WDATA;
        unique case (w_state)
            W_IDLE: if (wr_valid && wr_ready) begin
                aw_addr_nxt  = {wr_addr[ADDR_W-1:OFFS_W], OFFS_W'(0)};
                w_data_nxt   = wr_data;
                wr_ready_nxt = 1'b0;
                aw_valid_nxt = 1'b1;
                w_valid_nxt  = 1'b1;
                w_state_nxt  = W_REQ;
            end
            W_REQ: begin
                if (M_AXI_AWREADY) aw_valid_nxt = 1'b0;
                if (M_AXI_WREADY)  w_valid_nxt  = 1'b0;
                if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
                    b_ready_nxt = 1'b1;
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: if (M_AXI_BVALID) begin
                b_ready_nxt  = 1'b0;
                wr_ready_nxt = 1'b1;
                w_state_nxt  = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Read path next state; the fetched line is held until the consumer takes it
    always_comb begin
        r_state_nxt   = r_state;
        rd_aready_nxt = rd_aready;
        ar_valid_nxt  = M_AXI_ARVALID;
        r_ready_nxt   = M_AXI_RREADY;
        rd_valid_nxt  = rd_valid;
        ar_addr_nxt   = M_AXI_ARADDR;
        rd_data_nxt   = rd_data;
        unique case (r_state)
            R_IDLE: if (rd_avalid && rd_aready) begin
                ar_addr_nxt   = {rd_addr[ADDR_W-1:OFFS_W], OFFS_W'(0)};
                rd_aready_nxt = 1'b0;
                ar_valid_nxt  = 1'b1;
                r_state_nxt   = R_ADDR;
            end
            R_ADDR: if (M_AXI_ARREADY) begin
                ar_valid_nxt = 1'b0;
                r_ready_nxt  = 1'b1;
                r_state_nxt  = R_DATA;
            end
            R_DATA: if (M_AXI_RVALID) begin
                rd_data_nxt  = M_AXI_RDATA;
                r_ready_nxt  = 1'b0;
                rd_valid_nxt = 1'b1;
                r_state_nxt  = R_HOLD;
            end
            R_HOLD: if (rd_dready) begin
                rd_valid_nxt  = 1'b0;
                rd_aready_nxt = 1'b1;
                r_state_nxt   = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state       <= W_IDLE;
            wr_ready      <= 1'b1;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_WDATA   <= '0;
        end else begin
            w_state       <= w_state_nxt;
            wr_ready      <= wr_ready_nxt;
            M_AXI_AWVALID <= aw_valid_nxt;
            M_AXI_WVALID  <= w_valid_nxt;
            M_AXI_BREADY  <= b_ready_nxt;
            M_AXI_AWADDR  <= aw_addr_nxt;
            M_AXI_WDATA   <= w_data_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= R_IDLE;
            rd_aready     <= 1'b1;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rd_valid      <= 1'b0;
            M_AXI_ARADDR  <= '0;
            rd_data       <= '0;
        end else begin
            r_state       <= r_state_nxt;
            rd_aready     <= rd_aready_nxt;
            M_AXI_ARVALID <= ar_valid_nxt;
            M_AXI_RREADY  <= r_ready_nxt;
            rd_valid      <= rd_valid_nxt;
            M_AXI_ARADDR  <= ar_addr_nxt;
            rd_data       <= rd_data_nxt;
        end
    end
endmodule

// File: tb/tb_ddr_axi_master.sv
// Directed bench for ddr_axi_master: the bench plays the AXI slave and cache client,
// expected lines/addresses go through scoreboard queues and are checked on DUT output.
module tb_ddr_axi_master;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] wr_data;
    logic [26:0]  wr_addr;
    logic         wr_valid, wr_ready;
    logic [26:0]  rd_addr;
    logic         rd_avalid, rd_aready;
    logic [127:0] rd_data;
    logic         rd_valid, rd_dready;
    logic [26:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize, awprot, arprot;
    logic [1:0]   awburst, arburst, arlock, bresp, rresp;
    logic         awlock;
    logic [3:0]   awcache, arcache, awqos, arqos;
    logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic         arvalid, arready, rvalid, rready, rlast;
    logic [127:0] wdata, rdata;
    logic [15:0]  wstrb;

    typedef struct packed {
        logic [26:0]  addr;
        logic [127:0] data;
    } wexp_t;

    wexp_t        wq[$];
    logic [26:0]  arq[$];
    logic [127:0] rq[$];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ddr_axi_master dut (
        .clk(clk), .rst(rst),
        .wr_data(wr_data), .wr_addr(wr_addr), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_addr(rd_addr), .rd_avalid(rd_avalid), .rd_aready(rd_aready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_dready(rd_dready),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
        .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
        .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Pop expected write line and compare against the issued AW/W channels
    task automatic sb_write(output wexp_t e);
        chk("wq_nonempty", 128'(wq.size() > 0), 128'(1));
        e = (wq.size() > 0) ? wq.pop_front() : '0;
        chk("awaddr", 128'(awaddr), 128'(e.addr));
        chk("wdata", wdata, e.data);
        chk("wstrb", 128'(wstrb), 128'(16'hFFFF));
        chk("wlast", 128'(wlast), 128'(1));
    endtask

    task automatic sb_araddr();
        logic [26:0] e;
        chk("arq_nonempty", 128'(arq.size() > 0), 128'(1));
        e = (arq.size() > 0) ? arq.pop_front() : '0;
        chk("araddr", 128'(araddr), 128'(e));
    endtask

    task automatic sb_rdata();
        logic [127:0] e;
        chk("rq_nonempty", 128'(rq.size() > 0), 128'(1));
        e = (rq.size() > 0) ? rq.pop_front() : '0;
        chk("rd_data", rd_data, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        wexp_t        we;
        logic [26:0]  a;
        logic [127:0] d;
        rst = 1'b1;
        wr_data = '0; wr_addr = '0; wr_valid = 1'b0;
        rd_addr = '0; rd_avalid = 1'b0; rd_dready = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
        arready = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_wr_ready", 128'(wr_ready), 128'(1));
        chk("rst_rd_aready", 128'(rd_aready), 128'(1));
        chk("rst_valids", 128'({awvalid, wvalid, bready, arvalid, rready, rd_valid}), 128'(0));
        chk("rst_rd_data", rd_data, 128'(0));
        rst = 1'b0;
        tick();
        chk("idle_consts", 128'({awlen, awsize, awburst, awlock, awcache, awprot, awqos}),
            128'({8'd0, 3'b100, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0}));
        chk("idle_rconsts", 128'({arlen, arsize, arburst, arlock, arcache, arprot, arqos}),
            128'({8'd0, 3'b100, 2'b01, 2'b00, 4'b0011, 3'd0, 4'd0}));

        // Basic write, slave ready immediately, BVALID three cycles after issue
        wr_addr = 27'h0001234; wr_data = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        wr_valid = 1'b1; awready = 1'b1; wready = 1'b1;
        wq.push_back({27'h0001230, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF});
        tick();
        wr_valid = 1'b0; wr_addr = 27'h7FFFFFF; wr_data = '1;
        chk("w1_valids", 128'({awvalid, wvalid}), 128'(2'b11));
        chk("w1_wr_ready", 128'(wr_ready), 128'(0));
        sb_write(we);
        tick();
        chk("w1_bready", 128'({awvalid, wvalid, bready}), 128'(3'b001));
        tick();
        chk("w1_wait", 128'({wr_ready, bready}), 128'(2'b01));
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
        chk("w1_done", 128'({wr_ready, bready}), 128'(2'b10));

        // AWREADY late, WREADY immediate
        wr_addr = 27'h4455667; wr_data = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        wr_valid = 1'b1; wready = 1'b1;
        wq.push_back({27'h4455660, 128'h1111_2222_3333_4444_5555_6666_7777_8888});
        tick();
        wr_valid = 1'b0;
        sb_write(we);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("w2_aw_pending", 128'({awvalid, wvalid, bready, wr_ready}), 128'(4'b1000));
            chk("w2_awaddr_hold", 128'(awaddr), 128'(we.addr));
        end
        wready = 1'b0; awready = 1'b1;
        tick();
        awready = 1'b0;
        chk("w2_resp", 128'({awvalid, bready, wr_ready}), 128'(3'b010));
        bvalid = 1'b1;
        chk("w2_bvalid_cycle", 128'(wr_ready), 128'(0));
        tick();
        bvalid = 1'b0;
        chk("w2_done", 128'({wr_ready, bready}), 128'(2'b10));

        // Basic read, consumer ready early
        rd_addr = 27'h00ABCD0; rd_avalid = 1'b1; arready = 1'b1; rd_dready = 1'b1;
        arq.push_back(27'h00ABCD0);
        tick();
        rd_avalid = 1'b0;
        chk("r1_issue", 128'({arvalid, rd_aready, rready}), 128'(3'b100));
        sb_araddr();
        tick();
        arready = 1'b0;
        chk("r1_rready", 128'({arvalid, rready}), 128'(2'b01));
        rvalid = 1'b1; rlast = 1'b1; rdata = 128'h0123456789ABCDEF0123456789ABCDEF;
        rq.push_back(128'h0123456789ABCDEF0123456789ABCDEF);
        tick();
        rvalid = 1'b0; rlast = 1'b0; rdata = '0;
        chk("r1_valid", 128'({rd_valid, rready}), 128'(2'b10));
        sb_rdata();
        tick();
        rd_dready = 1'b0;
        chk("r1_idle", 128'({rd_valid, rd_aready}), 128'(2'b01));

        // Concurrent write and read with interleaved slave responses
        a = 27'($urandom); d = {$urandom, $urandom, $urandom, $urandom};
        wr_addr = a; wr_data = d; wr_valid = 1'b1;
        wq.push_back({a[26:4], 4'h0, d});
        a = 27'($urandom);
        rd_addr = a; rd_avalid = 1'b1;
        arq.push_back({a[26:4], 4'h0});
        tick();
        wr_valid = 1'b0; rd_avalid = 1'b0;
        wr_addr = ~wr_addr; wr_data = ~wr_data; rd_addr = ~rd_addr;
        chk("c_issue", 128'({awvalid, wvalid, arvalid, wr_ready, rd_aready}), 128'(5'b11100));
        sb_write(we);
        sb_araddr();
        arready = 1'b1;
        tick();
        arready = 1'b0; wready = 1'b1;
        d = {$urandom, $urandom, $urandom, $urandom};
        rvalid = 1'b1; rlast = 1'b1; rdata = d; rq.push_back(d);
        chk("c_ar_done", 128'({arvalid, rready, awvalid, wvalid}), 128'(4'b0111));
        tick();
        wready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = ~d; awready = 1'b1;
        chk("c_w_done", 128'({wvalid, awvalid, rd_valid}), 128'(3'b011));
        chk("c_awaddr_hold", 128'(awaddr), 128'(we.addr));
        sb_rdata();
        tick();
        awready = 1'b0; bvalid = 1'b1;
        chk("c_resp", 128'({awvalid, bready, rd_valid}), 128'(3'b011));
        chk("c_rd_hold", rd_data, d);
        tick();
        bvalid = 1'b0; rd_dready = 1'b1;
        chk("c_w_idle", 128'({wr_ready, rd_valid}), 128'(2'b11));
        tick();
        rd_dready = 1'b0;
        chk("c_r_idle", 128'({rd_valid, rd_aready, wr_ready}), 128'(3'b011));

        // Reset while waiting for read data abandons the transfer immediately
        rd_addr = 27'h0123450; rd_avalid = 1'b1; arready = 1'b1;
        tick();
        rd_avalid = 1'b0;
        tick();
        arready = 1'b0;
        chk("x_rready", 128'(rready), 128'(1));
        rst = 1'b1;
        #1;
        chk("x_async", 128'({rd_valid, arvalid, rready, rd_aready}), 128'(4'b0001));
        tick();
        rst = 1'b0;
        tick();
        chk("x_after", 128'({rd_aready, wr_ready, rd_valid}), 128'(3'b110));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
